// File: rtl/alu_pkg.sv
// Shared ALU definitions: precision encodings and the writeback FSM state type.
package alu_pkg;

  localparam logic [1:0] PREC_CHAR   = 2'b00;
  localparam logic [1:0] PREC_HALF   = 2'b01;
  localparam logic [1:0] PREC_FULL   = 2'b10;
  localparam logic [1:0] PREC_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_Y1 = 2'd1,
    WR_Y2 = 2'd2
  } wb_state_t;

endpackage

// File: rtl/precision_mask.sv
// Truncates a data word to the selected precision; CHAR/HALF are zero-extended.
module precision_mask
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        precision,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (precision)
      PREC_CHAR: result[7:0]  = data[7:0];
      PREC_HALF: result[15:0] = data[15:0];
      default:   result       = data;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Serialises an ALU {Y1, Y2} result pair onto the single register-file write
// port, Y1 first, and reports pending writes for RAW hazard checks.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int ZERO_DISCARD = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y1,
  input  logic [DATA_W-1:0] in_y2,
  input  logic [ADDR_W-1:0] in_dest1,
  input  logic [ADDR_W-1:0] in_dest2,
  input  logic [1:0]        in_mask,
  input  logic [1:0]        in_precision,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              hz_hit,
  output logic [CNT_W-1:0]  wb_count,
  output wb_state_t         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is derived from state and wb_ready only, never in_valid.

  wb_state_t         state, state_nxt;
  logic [DATA_W-1:0] e_y1, e_y2;
  logic [ADDR_W-1:0] e_d1, e_d2;
  logic [1:0]        e_mask;
  logic [1:0]        e_prec;
  logic [CNT_W-1:0]  count;
  logic [1:0]        ld_mask;
  logic              load;
  logic              last_write;
  logic [DATA_W-1:0] sel_y;
  logic [DATA_W-1:0] masked_y;

  localparam logic ZD = (ZERO_DISCARD != 0);

  // Writes to register 0 are dropped when the pair is captured.
  always_comb begin
    ld_mask    = in_mask;
    ld_mask[0] = in_mask[0] & ~(ZD & (in_dest1 == '0));
    ld_mask[1] = in_mask[1] & ~(ZD & (in_dest2 == '0));
  end

  assign last_write = (state == WR_Y2) || ((state == WR_Y1) && !e_mask[1]);
  assign in_ready   = (state == IDLE) || (wb_ready && last_write);
  assign load       = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    if (load) begin
      if (ld_mask[0])      state_nxt = WR_Y1;
      else if (ld_mask[1]) state_nxt = WR_Y2;
      else                 state_nxt = IDLE;
    end else begin
      case (state)
        WR_Y1:   if (wb_ready) state_nxt = e_mask[1] ? WR_Y2 : IDLE;
        WR_Y2:   if (wb_ready) state_nxt = IDLE;
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      e_y1   <= '0;
      e_y2   <= '0;
      e_d1   <= '0;
      e_d2   <= '0;
      e_mask <= '0;
      e_prec <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        e_y1   <= in_y1;
        e_y2   <= in_y2;
        e_d1   <= in_dest1;
        e_d2   <= in_dest2;
        e_mask <= ld_mask;
        e_prec <= in_precision;
      end
      if (wb_valid && wb_ready) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign sel_y = (state == WR_Y2) ? e_y2 : e_y1;

  precision_mask #(.DATA_W(DATA_W)) u_precision_mask (
    .data      (sel_y),
    .precision (e_prec),
    .result    (masked_y)
  );

  always_comb begin
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state)
      WR_Y1: begin
        wb_valid = 1'b1;
        wb_addr  = e_d1;
        wb_data  = masked_y;
      end
      WR_Y2: begin
        wb_valid = 1'b1;
        wb_addr  = e_d2;
        wb_data  = masked_y;
      end
      default: ;
    endcase
  end

  // Only the entry being drained counts; the offered in_* pair is not a hazard yet.
  assign hz_hit = ((state == WR_Y1) &&
                   ((hz_addr == e_d1) || (e_mask[1] && (hz_addr == e_d2)))) ||
                  ((state == WR_Y2) && (hz_addr == e_d2));

  assign wb_count  = count;
  assign dbg_state = state;

endmodule
